tiled_controller: RTL

Top-level sequencing controller for the systolic CNN array. It drives multi-tile jobs: a run-time number of weight tiles, each followed by a run-time number of input-feature (IF) tiles. The weight buffer is double-buffered. With OVERLAP=1 the next weight tile is prefetched into the shadow buffer while IF tiles stream against the active buffer. It sits between the host start/config registers and the weight/IF buffer fetch units (w_done, if_done).

---
 rtl/tile_ctrl_pkg.sv | 21 ++
 rtl/tiled_controller_if_sequencer.sv | 83 ++++++++
 rtl/tiled_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tile_ctrl_pkg.sv
// Shared state encodings and default sizing for the tiled CNN sequencing controller.
package tile_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    W_IDLE,
    W_CLR,
    W_LOAD,
    W_FULL,
    W_SWITCH,
    W_WAIT
  } w_state_e;

  typedef enum logic [1:0] {
    I_IDLE,
    I_CLR,
    I_STREAM
  } i_state_e;

endpackage

// File: rtl/tiled_controller_if_sequencer.sv
// IF tile sequencer: streams cfg IF tiles against the active weight buffer after each switch.
module if_sequencer
  import tile_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_cfg_if_tiles,
  input  logic             i_if_done,
  output logic             o_if_read,
  output logic             o_clr_if,
  output logic             o_drained,
  output logic [CNT_W-1:0] o_if_tile_idx,
  output logic             o_last_done_c
);

  localparam int unsigned XW = CNT_W + 1;

  i_state_e         r_state;
  logic             r_if_read;
  logic             r_clr_if;
  logic             r_drained;
  logic [CNT_W-1:0] r_idx;
  logic             w_more;

  // Widened compare so idx+1 cannot wrap when cfg is at its maximum.
  assign w_more        = ({1'b0, r_idx} + XW'(1)) < {1'b0, i_cfg_if_tiles};
  assign o_last_done_c = (r_state == I_STREAM) && i_if_done && !w_more;

  assign o_if_read     = r_if_read;
  assign o_clr_if      = r_clr_if;
  assign o_drained     = r_drained;
  assign o_if_tile_idx = r_idx;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= I_IDLE;
      r_idx     <= '0;
      r_if_read <= 1'b0;
      r_clr_if  <= 1'b0;
      r_drained <= 1'b1;
    end else begin
      case (r_state)
        I_IDLE: begin
          if (i_start) begin
            r_state   <= I_CLR;
            r_clr_if  <= 1'b1;
            r_drained <= 1'b0;
          end
        end
        I_CLR: begin
          r_state   <= I_STREAM;
          r_clr_if  <= 1'b0;
          r_if_read <= 1'b1;
        end
        I_STREAM: begin
          if (i_if_done) begin
            r_if_read <= 1'b0;
            if (w_more) begin
              r_idx    <= r_idx + CNT_W'(1);
              r_state  <= I_CLR;
              r_clr_if <= 1'b1;
            end else begin
              r_idx     <= '0;
              r_state   <= I_IDLE;
              r_drained <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= I_IDLE;
          r_idx     <= '0;
          r_if_read <= 1'b0;
          r_clr_if  <= 1'b0;
          r_drained <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/tiled_controller.sv
// Job sequencer for the systolic array: loads weight tiles into a double buffer and
// hands each one to the IF sequencer, optionally prefetching the next tile meanwhile.
module tiled_controller
  import tile_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_cfg_w_tiles,
  input  logic [CNT_W-1:0] i_cfg_if_tiles,
  input  logic             i_w_done,
  input  logic             i_if_done,
  output logic             o_w_read,
  output logic             o_if_read,
  output logic             o_clr_w,
  output logic             o_clr_if,
  output logic             o_switch,
  output logic             o_ready,
  output logic             o_done,
  output logic [CNT_W-1:0] o_w_tile_idx,
  output logic [CNT_W-1:0] o_if_tile_idx
);

  localparam int unsigned XW = CNT_W + 1;

  w_state_e         r_state;
  logic [CNT_W-1:0] r_w_idx;
  logic [CNT_W-1:0] r_cfg_w;
  logic [CNT_W-1:0] r_cfg_if;
  logic             r_last_w;
  logic             r_w_read;
  logic             r_clr_w;
  logic             r_switch;
  logic             r_ready;
  logic             r_done;

  logic             w_drained;
  logic             w_last_done_c;
  logic             w_accept;
  logic             w_more;
  logic             w_job_end;

  assign w_accept  = (r_state == W_IDLE) && w_drained && i_start &&
                     (i_cfg_w_tiles != '0) && (i_cfg_if_tiles != '0);
  assign w_more    = ({1'b0, r_w_idx} + XW'(1)) < {1'b0, r_cfg_w};
  assign w_job_end = r_last_w && w_last_done_c;

  assign o_w_read     = r_w_read;
  assign o_clr_w      = r_clr_w;
  assign o_switch     = r_switch;
  assign o_ready      = r_ready;
  assign o_done       = r_done;
  assign o_w_tile_idx = r_w_idx;

  // The switch pulse itself kicks off IF streaming of the newly active buffer.
  if_sequencer #(
    .CNT_W (CNT_W)
  ) u_if_seq (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (r_switch),
    .i_cfg_if_tiles (r_cfg_if),
    .i_if_done      (i_if_done),
    .o_if_read      (o_if_read),
    .o_clr_if       (o_clr_if),
    .o_drained      (w_drained),
    .o_if_tile_idx  (o_if_tile_idx),
    .o_last_done_c  (w_last_done_c)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= W_IDLE;
      r_w_idx  <= '0;
      r_cfg_w  <= '0;
      r_cfg_if <= '0;
      r_last_w <= 1'b0;
      r_w_read <= 1'b0;
      r_clr_w  <= 1'b0;
      r_switch <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_job_end;
      if (w_job_end) begin
        r_ready  <= 1'b1;
        r_last_w <= 1'b0;
      end
      case (r_state)
        W_IDLE: begin
          if (w_accept) begin
            r_state  <= W_CLR;
            r_clr_w  <= 1'b1;
            r_ready  <= 1'b0;
            r_w_idx  <= '0;
            r_cfg_w  <= i_cfg_w_tiles;
            r_cfg_if <= i_cfg_if_tiles;
          end
        end
        W_CLR: begin
          r_state  <= W_LOAD;
          r_clr_w  <= 1'b0;
          r_w_read <= 1'b1;
        end
        W_LOAD: begin
          if (i_w_done) begin
            r_state  <= W_FULL;
            r_w_read <= 1'b0;
          end
        end
        // Shadow buffer may only become active once the IF side has drained.
        W_FULL: begin
          if (w_drained) begin
            r_state  <= W_SWITCH;
            r_switch <= 1'b1;
          end
        end
        W_SWITCH: begin
          r_switch <= 1'b0;
          if (w_more) begin
            r_w_idx <= r_w_idx + CNT_W'(1);
            r_state <= W_WAIT;
          end else begin
            r_last_w <= 1'b1;
            r_state  <= W_IDLE;
          end
        end
        W_WAIT: begin
          if (OVERLAP || w_drained) begin
            r_state <= W_CLR;
            r_clr_w <= 1'b1;
          end
        end
        default: begin
          r_state  <= W_IDLE;
          r_w_read <= 1'b0;
          r_clr_w  <= 1'b0;
          r_switch <= 1'b0;
        end
      endcase
    end
  end

endmodule
